// File: rtl/cache_if.sv
// cache_if: bundle of every handshake and bus signal around cache_ctrl.
//
// Signal groups:
//   CPU side     : req_valid/req_ready/req_addr/req_we/req_wdata in,
//                  resp_valid/resp_rdata/resp_hit back.
//   Memory side  : mem_req_valid/mem_req_ready/mem_we/mem_addr/mem_wdata out,
//                  mem_resp_valid/mem_rdata back.
//   Replacement  : index/asso_index/read_trigger/write_trigger to the lru
//                  block, select (victim way) back from it.
//
// Handshake rules: a request transfers on a rising clk edge where both valid
// and ready are high; the sender keeps valid and its payload stable until that
// edge; the receiver may raise ready independently of valid. resp_valid and
// mem_resp_valid are single-cycle pulses with no back-pressure.
//
// modport master : the cache controller's view.
// modport slave  : the environment's view (CPU, memory and lru combined).
interface cache_if #(
    parameter int INDEX_SIZE    = 4,
    parameter int ASSOCIATIVITY = 2,
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8
);
    localparam int NUM_INDICES = $clog2(INDEX_SIZE);
    localparam int COUNT_SIZE  = $clog2(ASSOCIATIVITY);

    logic                   req_valid;
    logic                   req_ready;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic                   req_we;
    logic [DATA_WIDTH-1:0]  req_wdata;
    logic                   resp_valid;
    logic [DATA_WIDTH-1:0]  resp_rdata;
    logic                   resp_hit;

    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0]  mem_wdata;
    logic                   mem_resp_valid;
    logic [DATA_WIDTH-1:0]  mem_rdata;

    logic [NUM_INDICES-1:0] index;
    logic [COUNT_SIZE-1:0]  asso_index;
    logic [COUNT_SIZE-1:0]  select;
    logic                   read_trigger;
    logic                   write_trigger;

    modport master (
        input  req_valid, req_addr, req_we, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_hit,
        output mem_req_valid, mem_we, mem_addr, mem_wdata,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output index, asso_index, read_trigger, write_trigger,
        input  select
    );

    modport slave (
        output req_valid, req_addr, req_we, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_hit,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  index, asso_index, read_trigger, write_trigger,
        output select
    );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl: set-associative, write-back, write-allocate cache controller
// with one-word lines. Holds tag/valid/dirty/data arrays, serves the CPU
// request/response handshake, issues writebacks and fills to memory, and
// drives the lru replacement block (which supplies the victim way).
//
// Ports:
//   clk     : clock, all logic on posedge.
//   reset   : synchronous, active-high; clears valid/dirty and aborts any
//             in-flight operation (tag/data arrays keep their contents).
//   bus     : cache_if.master, CPU, memory and replacement-block signals.
//   state_o : current FSM state, for observation.
module cache_ctrl #(
    parameter int INDEX_SIZE    = 4,
    parameter int ASSOCIATIVITY = 2,
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic         clk,
    input  logic         reset,
    cache_if.master      bus,
    output logic [2:0]   state_o
);
    localparam int NUM_INDICES = $clog2(INDEX_SIZE);
    localparam int COUNT_SIZE  = $clog2(ASSOCIATIVITY);
    localparam int TAG_W       = ADDR_WIDTH - NUM_INDICES;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_WB        = 3'd2,
        S_FILL      = 3'd3,
        S_FILL_WAIT = 3'd4,
        S_RESP      = 3'd5
    } state_t;

    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   we_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic                   hit_q;
    logic [COUNT_SIZE-1:0]  victim_q;
    logic [NUM_INDICES-1:0] index_q;
    logic [COUNT_SIZE-1:0]  asso_index_q;
    logic                   read_trigger_q;
    logic                   req_ready_q;
    logic                   resp_valid_q;
    logic [DATA_WIDTH-1:0]  resp_rdata_q;
    logic                   resp_hit_q;
    logic                   mem_req_valid_q;
    logic                   mem_we_q;
    logic [ADDR_WIDTH-1:0]  mem_addr_q;
    logic [DATA_WIDTH-1:0]  mem_wdata_q;

    logic [TAG_W-1:0]         tag_q   [INDEX_SIZE][ASSOCIATIVITY];
    logic [DATA_WIDTH-1:0]    data_q  [INDEX_SIZE][ASSOCIATIVITY];
    logic [ASSOCIATIVITY-1:0] valid_q [INDEX_SIZE];
    logic [ASSOCIATIVITY-1:0] dirty_q [INDEX_SIZE];

    logic [NUM_INDICES-1:0] req_idx;
    logic [TAG_W-1:0]       req_tag;
    logic [NUM_INDICES-1:0] lat_idx;
    logic [TAG_W-1:0]       lat_tag;
    logic                   hit_d;
    logic [COUNT_SIZE-1:0]  hit_way_d;
    logic [COUNT_SIZE-1:0]  victim_d;

    assign req_idx = bus.req_addr[NUM_INDICES-1:0];
    assign req_tag = bus.req_addr[ADDR_WIDTH-1:NUM_INDICES];
    assign lat_idx = addr_q[NUM_INDICES-1:0];
    assign lat_tag = addr_q[ADDR_WIDTH-1:NUM_INDICES];

    // The tag compare runs on the incoming address while still in IDLE. The
    // arrays cannot change between acceptance and LOOKUP, so registering the
    // result lets read_trigger and asso_index be flops that are valid for the
    // whole LOOKUP cycle. Scanning downwards makes the lowest matching way win.
    always_comb begin
        hit_d     = 1'b0;
        hit_way_d = '0;
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit_d     = 1'b1;
                hit_way_d = COUNT_SIZE'(w);
            end
        end
    end

    // An out-of-range way from the replacement block falls back to way 0.
    always_comb begin
        victim_d = bus.select;
        if (32'(bus.select) >= ASSOCIATIVITY) begin
            victim_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            read_trigger_q  <= 1'b0;
            for (int s = 0; s < INDEX_SIZE; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            resp_valid_q   <= 1'b0;
            read_trigger_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q         <= bus.req_addr;
                        we_q           <= bus.req_we;
                        wdata_q        <= bus.req_wdata;
                        index_q        <= req_idx;
                        hit_q          <= hit_d;
                        asso_index_q   <= hit_way_d;
                        read_trigger_q <= hit_d;
                        req_ready_q    <= 1'b0;
                        state_q        <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit_q) begin
                        if (we_q) begin
                            data_q[lat_idx][asso_index_q]  <= wdata_q;
                            dirty_q[lat_idx][asso_index_q] <= 1'b1;
                            resp_rdata_q                   <= wdata_q;
                        end else begin
                            resp_rdata_q <= data_q[lat_idx][asso_index_q];
                        end
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        victim_q        <= victim_d;
                        asso_index_q    <= victim_d;
                        mem_req_valid_q <= 1'b1;
                        if (valid_q[lat_idx][victim_d] && dirty_q[lat_idx][victim_d]) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {tag_q[lat_idx][victim_d], lat_idx};
                            mem_wdata_q <= data_q[lat_idx][victim_d];
                            state_q     <= S_WB;
                        end else begin
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= addr_q;
                            state_q    <= S_FILL;
                        end
                    end
                end
                S_WB: begin
                    // Writeback accepted: the fill read follows back to back.
                    if (bus.mem_req_ready) begin
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= addr_q;
                        state_q    <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= S_FILL_WAIT;
                    end
                end
                S_FILL_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        valid_q[lat_idx][victim_q] <= 1'b1;
                        dirty_q[lat_idx][victim_q] <= we_q;
                        tag_q[lat_idx][victim_q]   <= lat_tag;
                        data_q[lat_idx][victim_q]  <= we_q ? wdata_q : bus.mem_rdata;
                        resp_rdata_q               <= we_q ? wdata_q : bus.mem_rdata;
                        resp_valid_q               <= 1'b1;
                        resp_hit_q                 <= 1'b0;
                        state_q                    <= S_RESP;
                    end
                end
                S_RESP: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // The fill pulse must coincide with the cycle the victim way is installed,
    // which is only known from mem_resp_valid in that same cycle.
    assign bus.write_trigger = !reset && (state_q == S_FILL_WAIT) && bus.mem_resp_valid;

    assign bus.req_ready     = req_ready_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.resp_hit      = resp_hit_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.index         = index_q;
    assign bus.asso_index    = asso_index_q;
    assign bus.read_trigger  = read_trigger_q;
    assign state_o           = state_q;
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed bench for cache_ctrl (4 sets, 2 ways, 8-bit
// addresses and data). A memory responder serves fills and absorbs
// writebacks; a trigger monitor counts replacement-block pulses.
module tb_cache_ctrl;
    logic       clk;
    logic       reset;
    logic [2:0] dbg_state;

    cache_if #(.INDEX_SIZE(4), .ASSOCIATIVITY(2), .ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    cache_ctrl #(.INDEX_SIZE(4), .ASSOCIATIVITY(2), .ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- memory model / responder ----------------
    logic [7:0] mem_model [256];
    logic [7:0] log_addr_q [$];
    logic       log_we_q [$];
    logic [7:0] log_data_q [$];
    int         stall_cycles = 0;   // main-owned
    bit         hold_fill = 1'b0;   // main-owned: accept fill but never answer
    int         inject_seq = 0;     // main-owned: bump to send a stray response
    int         inject_ack = 0;
    int         stall_cnt = 0;
    bit         resp_due = 1'b0;
    logic [7:0] pend_data = 8'h00;

    initial begin
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            if (inject_seq != inject_ack) begin
                inject_ack         = inject_seq;
                bus.mem_resp_valid = 1'b1;
                bus.mem_rdata      = 8'hEE;
            end else if (resp_due) begin
                resp_due           = 1'b0;
                bus.mem_resp_valid = 1'b1;
                bus.mem_rdata      = pend_data;
            end else if (bus.mem_req_valid && !reset) begin
                if (stall_cnt < stall_cycles) begin
                    stall_cnt++;
                end else begin
                    stall_cnt         = 0;
                    bus.mem_req_ready = 1'b1;
                    log_addr_q.push_back(bus.mem_addr);
                    log_we_q.push_back(bus.mem_we);
                    log_data_q.push_back(bus.mem_wdata);
                    if (bus.mem_we) begin
                        mem_model[bus.mem_addr] = bus.mem_wdata;
                    end else if (!hold_fill) begin
                        resp_due  = 1'b1;
                        pend_data = mem_model[bus.mem_addr];
                    end
                end
            end
        end
    end

    // ---------------- trigger monitor ----------------
    int         wt_cnt = 0, rt_cnt = 0, both_hi = 0, gap_viol = 0;
    logic [1:0] wt_idx = 2'd0;
    logic       rt_asso = 1'b0;
    bit         rt_h1 = 0, rt_h2 = 0, wt_h1 = 0, wt_h2 = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.write_trigger) begin
                wt_cnt++;
                wt_idx = bus.index;
            end
            if (bus.read_trigger) begin
                rt_cnt++;
                rt_asso = bus.asso_index;
            end
            if (bus.read_trigger && bus.write_trigger) both_hi++;
            if ((bus.read_trigger && (rt_h1 || rt_h2)) || (bus.write_trigger && (wt_h1 || wt_h2)))
                gap_viol++;
            rt_h2 = rt_h1;
            rt_h1 = bus.read_trigger;
            wt_h2 = wt_h1;
            wt_h1 = bus.write_trigger;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input string tag, input logic [7:0] addr, input logic we,
                            input logic [7:0] wd, input logic sel);
        int guard = 0;
        while (!bus.req_ready && guard < 200) begin
            tick();
            guard++;
        end
        check({tag, "_ready"}, 32'(bus.req_ready), 32'h1);
        bus.select    = sel;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_we    = we;
        bus.req_wdata = wd;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, output int lat, output logic [7:0] rdata,
                             output logic hit);
        logic got = 1'b0;
        lat   = 0;
        rdata = 8'h00;
        hit   = 1'b0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid) begin
                got   = 1'b1;
                rdata = bus.resp_rdata;
                hit   = bus.resp_hit;
            end
        end
        check({tag, "_resp_seen"}, 32'(got), 32'h1);
    endtask

    // ---------------- main sequence ----------------
    int         lat, n0, rt0, wt0, unstable, guard;
    logic [7:0] rd, a0;
    logic       hit, w0, reached;

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_we    = 1'b0;
        bus.req_wdata = 8'h00;
        bus.select    = 1'b0;
        for (int i = 0; i < 256; i++) mem_model[i] = 8'(i ^ 8'h5C);
        mem_model[8'h05] = 8'hAB;
        mem_model[8'h09] = 8'h33;
        mem_model[8'h0D] = 8'h44;
        mem_model[8'h02] = 8'h77;
        mem_model[8'h22] = 8'h99;
        mem_model[8'h26] = 8'h3C;

        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'h1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'h0);
        check("rst_read_trigger", 32'(bus.read_trigger), 32'h0);
        check("rst_write_trigger", 32'(bus.write_trigger), 32'h0);

        // 1: cold read miss of 0x05, filled into way 0
        wt0 = wt_cnt;
        send_req("s1", 8'h05, 1'b0, 8'h00, 1'b0);
        wait_resp("s1", lat, rd, hit);
        check("s1_rdata", 32'(rd), 32'hAB);
        check("s1_hit", 32'(hit), 32'h0);
        check("s1_latency", 32'(lat), 32'd4);
        check("s1_mem_n", 32'(log_addr_q.size()), 32'd1);
        check("s1_mem_addr", 32'(log_addr_q[0]), 32'h05);
        check("s1_mem_we", 32'(log_we_q[0]), 32'h0);
        check("s1_wt_pulses", 32'(wt_cnt - wt0), 32'd1);
        check("s1_wt_index", 32'(wt_idx), 32'd1);

        // 2: read hit of 0x05
        n0  = log_addr_q.size();
        rt0 = rt_cnt;
        send_req("s2", 8'h05, 1'b0, 8'h00, 1'b0);
        wait_resp("s2", lat, rd, hit);
        check("s2_latency", 32'(lat), 32'd2);
        check("s2_rdata", 32'(rd), 32'hAB);
        check("s2_hit", 32'(hit), 32'h1);
        check("s2_rt_pulses", 32'(rt_cnt - rt0), 32'd1);
        check("s2_asso_index", 32'(rt_asso), 32'd0);
        check("s2_no_mem", 32'(log_addr_q.size()), 32'(n0));
        @(negedge clk);
        check("s2_resp_one_cycle", 32'(bus.resp_valid), 32'h0);

        // 3: write hit makes 0x05 dirty; 0x09 fills way 1; 0x0D evicts way 0
        send_req("s3w", 8'h05, 1'b1, 8'h11, 1'b0);
        wait_resp("s3w", lat, rd, hit);
        check("s3w_latency", 32'(lat), 32'd2);
        check("s3w_rdata", 32'(rd), 32'h11);
        check("s3w_hit", 32'(hit), 32'h1);
        send_req("s3a", 8'h09, 1'b0, 8'h00, 1'b1);
        wait_resp("s3a", lat, rd, hit);
        check("s3a_rdata", 32'(rd), 32'h33);
        check("s3a_hit", 32'(hit), 32'h0);
        n0 = log_addr_q.size();
        send_req("s3b", 8'h0D, 1'b0, 8'h00, 1'b0);
        wait_resp("s3b", lat, rd, hit);
        check("s3b_rdata", 32'(rd), 32'h44);
        check("s3b_hit", 32'(hit), 32'h0);
        check("s3b_mem_n", 32'(log_addr_q.size()), 32'(n0 + 2));
        check("s3b_wb_we", 32'(log_we_q[n0]), 32'h1);
        check("s3b_wb_addr", 32'(log_addr_q[n0]), 32'h05);
        check("s3b_wb_data", 32'(log_data_q[n0]), 32'h11);
        check("s3b_fill_we", 32'(log_we_q[n0+1]), 32'h0);
        check("s3b_fill_addr", 32'(log_addr_q[n0+1]), 32'h0D);

        // 4: fill of 0x02 with memory stalling 5 cycles
        stall_cycles = 5;
        n0 = log_addr_q.size();
        send_req("s4", 8'h02, 1'b0, 8'h00, 1'b0);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.mem_req_valid && guard < 50);
        check("s4_mem_req_seen", 32'(bus.mem_req_valid), 32'h1);
        a0 = bus.mem_addr;
        w0 = bus.mem_we;
        check("s4_mem_addr", 32'(a0), 32'h02);
        check("s4_mem_we", 32'(w0), 32'h0);
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!bus.mem_req_valid || bus.mem_addr != a0 || bus.mem_we != w0 || bus.req_ready)
                unstable++;
        end
        check("s4_stable", 32'(unstable), 32'd0);
        wait_resp("s4", lat, rd, hit);
        stall_cycles = 0;
        check("s4_rdata", 32'(rd), 32'h77);
        check("s4_hit", 32'(hit), 32'h0);
        check("s4_single_accept", 32'(log_addr_q.size()), 32'(n0 + 1));

        // 5: reset while waiting for fill data, then a stray response
        hold_fill = 1'b1;
        wt0 = wt_cnt;
        send_req("s5", 8'h06, 1'b0, 8'h00, 1'b0);
        guard   = 0;
        reached = 1'b0;
        while (!reached && guard < 50) begin
            if (dbg_state == 3'd4) reached = 1'b1;
            else begin
                tick();
                guard++;
            end
        end
        check("s5_reach_fill_wait", 32'(reached), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        inject_seq++;
        @(negedge clk);
        check("s5_stray_resp_driven", 32'(bus.mem_resp_valid), 32'h1);
        check("s5_mem_req_valid", 32'(bus.mem_req_valid), 32'h0);
        check("s5_req_ready", 32'(bus.req_ready), 32'h1);
        check("s5_resp_valid", 32'(bus.resp_valid), 32'h0);
        @(negedge clk);
        check("s5_resp_valid_after", 32'(bus.resp_valid), 32'h0);
        check("s5_req_ready_after", 32'(bus.req_ready), 32'h1);
        check("s5_no_wt", 32'(wt_cnt - wt0), 32'd0);
        hold_fill = 1'b0;
        send_req("s5r", 8'h05, 1'b0, 8'h00, 1'b0);
        wait_resp("s5r", lat, rd, hit);
        check("s5r_hit", 32'(hit), 32'h0);
        check("s5r_rdata", 32'(rd), 32'h11);

        // 6: write-allocate miss, hit on it, then its dirty eviction
        n0 = log_addr_q.size();
        send_req("s6w", 8'h22, 1'b1, 8'h5A, 1'b1);
        wait_resp("s6w", lat, rd, hit);
        check("s6w_hit", 32'(hit), 32'h0);
        check("s6w_rdata", 32'(rd), 32'h5A);
        check("s6w_fill_we", 32'(log_we_q[n0]), 32'h0);
        check("s6w_fill_addr", 32'(log_addr_q[n0]), 32'h22);
        rt0 = rt_cnt;
        send_req("s6r", 8'h22, 1'b0, 8'h00, 1'b1);
        wait_resp("s6r", lat, rd, hit);
        check("s6r_hit", 32'(hit), 32'h1);
        check("s6r_rdata", 32'(rd), 32'h5A);
        check("s6r_latency", 32'(lat), 32'd2);
        check("s6r_asso_index", 32'(rt_asso), 32'd1);
        check("s6r_rt_pulses", 32'(rt_cnt - rt0), 32'd1);
        n0 = log_addr_q.size();
        send_req("s6e", 8'h26, 1'b0, 8'h00, 1'b1);
        wait_resp("s6e", lat, rd, hit);
        check("s6e_rdata", 32'(rd), 32'h3C);
        check("s6e_wb_we", 32'(log_we_q[n0]), 32'h1);
        check("s6e_wb_addr", 32'(log_addr_q[n0]), 32'h22);
        check("s6e_wb_data", 32'(log_data_q[n0]), 32'h5A);
        check("s6e_fill_addr", 32'(log_addr_q[n0+1]), 32'h26);

        // trigger bookkeeping over the whole run
        @(negedge clk);
        check("wt_total", 32'(wt_cnt), 32'd7);
        check("rt_total", 32'(rt_cnt), 32'd3);
        check("triggers_overlap", 32'(both_hi), 32'd0);
        check("trigger_gap", 32'(gap_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
